// File: rtl/i2c_master_arbiter_pkg.sv
// Shared types and constants for the I2C master arbiter.
package i2c_arb_pkg;

  localparam int ADDR_W           = 7;
  localparam int DATA_W           = 8;
  localparam int START_TO_DEFAULT = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT_DONE,
    ST_DONE
  } arbState_e;

  // One requester's command as presented to the master.
  typedef struct packed {
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] blockAddr;
    logic [DATA_W-1:0] data;
  } arbCmd_t;

  // Increment a requester index with wrap-around at n.
  function automatic int wrapInc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/i2c_master_arbiter_if.sv
// Bundle of requester-side and master-side signals around the arbiter.
// The master modport is the arbiter's view; slave is the surrounding logic.
interface i2c_master_arbiter_if #(
  parameter int N_REQ = 4
);
  import i2c_arb_pkg::*;

  // Requester side
  logic [N_REQ-1:0]        req;
  logic [N_REQ-1:0]        req_rw;
  logic [ADDR_W*N_REQ-1:0] req_addr;
  logic [DATA_W*N_REQ-1:0] req_block_addr;
  logic [DATA_W*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]        gnt;
  logic [N_REQ-1:0]        done;
  logic [DATA_W-1:0]       rd_data;
  logic                    rd_ack;
  logic                    err;

  // i2c_master side
  logic                    m_enable;
  logic                    m_rw;
  logic [ADDR_W-1:0]       m_addr;
  logic [DATA_W-1:0]       m_block_addr;
  logic [DATA_W-1:0]       m_data_in;
  logic                    m_busy;
  logic [DATA_W-1:0]       m_data_out;
  logic                    m_ack;

  modport master (
    input  req, req_rw, req_addr, req_block_addr, req_data,
    input  m_busy, m_data_out, m_ack,
    output gnt, done, rd_data, rd_ack, err,
    output m_enable, m_rw, m_addr, m_block_addr, m_data_in
  );

  modport slave (
    output req, req_rw, req_addr, req_block_addr, req_data,
    output m_busy, m_data_out, m_ack,
    input  gnt, done, rd_data, rd_ack, err,
    input  m_enable, m_rw, m_addr, m_block_addr, m_data_in
  );

endinterface

// File: rtl/i2c_master_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr,
// searching upward with wrap. Reusable for any request vector width.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N_REQ-1:0] grant_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             valid_o
);

  int   cand;
  logic found;

  // Walk the requesters starting at ptr and keep the first one asserted.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    cand    = 0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = (int'(ptr_i) + i) % N_REQ;
      if (!found && req_i[cand]) begin
        found         = 1'b1;
        grant_o[cand] = 1'b1;
        idx_o         = IDX_W'(cand);
      end
    end
  end

  assign valid_o = found;

endmodule

// File: rtl/i2c_master_arbiter.sv
// Round-robin arbiter sharing one i2c_master between N_REQ requesters.
// The winner's command is latched at grant so only a stable command ever
// reaches the master, regardless of what the requesters do afterwards.
module i2c_master_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int START_TO = START_TO_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  i2c_master_arbiter_if.master bus
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = $clog2(START_TO + 2) + 1;
  // START is abandoned on the (START_TO+2)-th edge after entry: START_TO
  // cycles of grace beyond the master's one-cycle enable-to-busy latency,
  // plus the registered abort decision.
  localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(START_TO + 1);

  arbState_e         state_q;
  logic [IDX_W-1:0]  ptr_q;
  logic [IDX_W-1:0]  ptr_d;
  logic [N_REQ-1:0]  gnt_q;
  logic [N_REQ-1:0]  done_q;
  logic [DATA_W-1:0] rdData_q;
  logic              rdAck_q;
  logic              err_q;
  logic              mEnable_q;
  logic [CNT_W-1:0]  startCnt_q;
  arbCmd_t           cmd_q;
  arbCmd_t           cmd_d;

  logic [N_REQ-1:0]  winOneHot;
  logic [IDX_W-1:0]  winIdx;
  logic              winValid;

  rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) uPick (
    .req_i   (bus.req),
    .ptr_i   (ptr_q),
    .grant_o (winOneHot),
    .idx_o   (winIdx),
    .valid_o (winValid)
  );

  // Pointer moves just past the winner so it gets lowest priority next time.
  assign ptr_d = IDX_W'(wrapInc(int'(winIdx), N_REQ));

  // Gather the current winner's payload out of the packed request buses.
  always_comb begin
    cmd_d           = '0;
    cmd_d.rw        = bus.req_rw[winIdx];
    cmd_d.addr      = bus.req_addr[int'(winIdx)*ADDR_W +: ADDR_W];
    cmd_d.blockAddr = bus.req_block_addr[int'(winIdx)*DATA_W +: DATA_W];
    cmd_d.data      = bus.req_data[int'(winIdx)*DATA_W +: DATA_W];
  end

  // Arbitration FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      gnt_q      <= '0;
      done_q     <= '0;
      rdData_q   <= '0;
      rdAck_q    <= 1'b0;
      err_q      <= 1'b0;
      mEnable_q  <= 1'b0;
      startCnt_q <= '0;
      cmd_q      <= '0;
    end else begin
      done_q <= '0;
      case (state_q)
        ST_IDLE: begin
          if (winValid) begin
            gnt_q      <= winOneHot;
            ptr_q      <= ptr_d;
            cmd_q      <= cmd_d;
            mEnable_q  <= 1'b1;
            startCnt_q <= '0;
            state_q    <= ST_START;
          end
        end
        ST_START: begin
          if (bus.m_busy) begin
            mEnable_q <= 1'b0;
            state_q   <= ST_WAIT_DONE;
          end else if (startCnt_q == TO_LIMIT) begin
            mEnable_q <= 1'b0;
            err_q     <= 1'b1;
            rdAck_q   <= 1'b0;
            done_q    <= gnt_q;
            state_q   <= ST_DONE;
          end else begin
            startCnt_q <= startCnt_q + CNT_W'(1);
          end
        end
        ST_WAIT_DONE: begin
          if (!bus.m_busy) begin
            rdData_q <= bus.m_data_out;
            rdAck_q  <= bus.m_ack;
            err_q    <= 1'b0;
            done_q   <= gnt_q;
            state_q  <= ST_DONE;
          end
        end
        ST_DONE: begin
          gnt_q   <= '0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.gnt          = gnt_q;
  assign bus.done         = done_q;
  assign bus.rd_data      = rdData_q;
  assign bus.rd_ack       = rdAck_q;
  assign bus.err          = err_q;
  assign bus.m_enable     = mEnable_q;
  assign bus.m_rw         = cmd_q.rw;
  assign bus.m_addr       = cmd_q.addr;
  assign bus.m_block_addr = cmd_q.blockAddr;
  assign bus.m_data_in    = cmd_q.data;

endmodule

// File: tb/tb_i2c_master_arbiter.sv
// Self-checking bench for i2c_master_arbiter with a behavioural i2c_master
// stand-in and a transaction-level round-robin reference model.
module tb_i2c_master_arbiter;
  import i2c_arb_pkg::*;

  localparam int N  = 4;
  localparam int TO = 16;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  int vectors     = 0;
  int miscompares = 0;

  i2c_master_arbiter_if #(.N_REQ(N)) bus ();

  i2c_master_arbiter #(
    .N_REQ    (N),
    .START_TO (TO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Requester stimulus, owned by the main thread.
  logic [N-1:0] sReq;
  logic [N-1:0] sRw;
  logic [6:0]   sAddr  [N];
  logic [7:0]   sBlock [N];
  logic [7:0]   sData  [N];

  // Master stand-in controls and reference-model state.
  bit         mdlNoBusy = 1'b0;
  int         mdlLen    = 1;
  logic [7:0] mdlRdData = 8'h00;
  bit         mdlRdAck  = 1'b0;
  int         mdlPtr    = 0;

  // Master stand-in: busy rises the cycle after enable is seen, stays high
  // for mdlLen cycles, then drops with the read data and ack.
  int   mCnt = 0;
  logic enSeen;
  logic rstSeen;
  always @(posedge clk) begin
    enSeen  = bus.m_enable;
    rstSeen = reset;
    #1;
    if (!rstSeen) begin
      bus.m_busy     = 1'b0;
      bus.m_data_out = 8'h00;
      bus.m_ack      = 1'b0;
      mCnt           = 0;
    end else if (mCnt > 0) begin
      mCnt--;
      if (mCnt == 0) begin
        bus.m_busy     = 1'b0;
        bus.m_data_out = mdlRdData;
        bus.m_ack      = mdlRdAck;
      end
    end else if (enSeen && !bus.m_busy && !mdlNoBusy) begin
      bus.m_busy     = 1'b1;
      mCnt           = mdlLen;
      bus.m_data_out = 8'($urandom);
      bus.m_ack      = 1'($urandom);
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus();
    for (int i = 0; i < N; i++) begin
      bus.req_addr[i*ADDR_W +: ADDR_W]       = sAddr[i];
      bus.req_block_addr[i*DATA_W +: DATA_W] = sBlock[i];
      bus.req_data[i*DATA_W +: DATA_W]       = sData[i];
    end
    bus.req    = sReq;
    bus.req_rw = sRw;
  endtask

  task automatic randomizePayloads();
    for (int i = 0; i < N; i++) begin
      sAddr[i]  = 7'($urandom);
      sBlock[i] = 8'($urandom);
      sData[i]  = 8'($urandom);
    end
    sRw = N'($urandom);
  endtask

  // Round-robin rule: first requester at or after ptr, upward with wrap.
  function automatic int modelPick(input logic [N-1:0] m, input int p);
    for (int k = 0; k < N; k++)
      if (m[(p + k) % N]) return (p + k) % N;
    return 0;
  endfunction

  task automatic checkResetState(input string tag);
    checkOutput({tag, ".gnt"},       32'(bus.gnt), 32'd0);
    checkOutput({tag, ".done"},      32'(bus.done), 32'd0);
    checkOutput({tag, ".rdData"},    32'(bus.rd_data), 32'd0);
    checkOutput({tag, ".rdAck"},     32'(bus.rd_ack), 32'd0);
    checkOutput({tag, ".err"},       32'(bus.err), 32'd0);
    checkOutput({tag, ".mEnable"},   32'(bus.m_enable), 32'd0);
    checkOutput({tag, ".mRw"},       32'(bus.m_rw), 32'd0);
    checkOutput({tag, ".mAddr"},     32'(bus.m_addr), 32'd0);
    checkOutput({tag, ".mBlock"},    32'(bus.m_block_addr), 32'd0);
    checkOutput({tag, ".mDataIn"},   32'(bus.m_data_in), 32'd0);
  endtask

  // One full arbitrated transfer, entered with the DUT idle and sReq applied.
  task automatic doTransfer(input int len, input bit noBusy, input bit holdReq,
                            input logic [7:0] rdVal, input bit ackVal);
    int           g;
    int           waited;
    logic [N-1:0] expOH;
    logic [6:0]   eAddr;
    logic [7:0]   eBlock;
    logic [7:0]   eData;
    logic         eRw;
    mdlNoBusy = noBusy;
    mdlLen    = len;
    mdlRdData = rdVal;
    mdlRdAck  = ackVal;
    g         = modelPick(sReq, mdlPtr);
    expOH     = '0;
    expOH[g]  = 1'b1;
    eAddr     = sAddr[g];
    eBlock    = sBlock[g];
    eData     = sData[g];
    eRw       = sRw[g];

    waited = 0;
    do begin
      @(posedge clk); #1;
      waited++;
    end while (bus.gnt == '0 && waited < 50);
    checkOutput("gntLat",  32'(waited), 32'd1);
    checkOutput("gnt",     32'(bus.gnt), 32'(expOH));
    checkOutput("mEnable", 32'(bus.m_enable), 32'd1);
    checkOutput("mAddr",   32'(bus.m_addr), 32'(eAddr));
    checkOutput("mBlock",  32'(bus.m_block_addr), 32'(eBlock));
    checkOutput("mDataIn", 32'(bus.m_data_in), 32'(eData));
    checkOutput("mRw",     32'(bus.m_rw), 32'(eRw));
    mdlPtr = (g + 1) % N;

    waited = 0;
    do begin
      @(posedge clk); #1;
      waited++;
      if (waited == 2 && !noBusy)
        checkOutput("mEnableLow", 32'(bus.m_enable), 32'd0);
      if (waited == 3) begin
        for (int i = 0; i < N; i++) begin
          sAddr[i]  = sAddr[i] ^ 7'h55;
          sBlock[i] = sBlock[i] ^ 8'h5A;
          sData[i]  = sData[i] ^ 8'hEE;
        end
        sRw = ~sRw;
        if (!holdReq && $urandom_range(0, 3) == 0) sReq[g] = 1'b0;
        applyStimulus();
      end
    end while (bus.done == '0 && waited < 200);
    checkOutput("doneLat",  32'(waited), noBusy ? 32'(TO + 2) : 32'(len + 2));
    checkOutput("done",     32'(bus.done), 32'(expOH));
    checkOutput("gntHeld",  32'(bus.gnt), 32'(expOH));
    checkOutput("err",      32'(bus.err), 32'(noBusy));
    checkOutput("mDataHeld", 32'(bus.m_data_in), 32'(eData));
    checkOutput("mAddrHeld", 32'(bus.m_addr), 32'(eAddr));
    checkOutput("mRwHeld",   32'(bus.m_rw), 32'(eRw));
    if (!noBusy) begin
      checkOutput("rdData", 32'(bus.rd_data), 32'(rdVal));
      checkOutput("rdAck",  32'(bus.rd_ack), 32'(ackVal));
    end
    if (!holdReq) begin
      sReq[g] = 1'b0;
      applyStimulus();
    end

    @(posedge clk); #1;
    checkOutput("idleGap", 32'({bus.gnt, bus.done}), 32'd0);
  endtask

  initial begin
    sReq = '0;
    randomizePayloads();
    applyStimulus();
    repeat (3) @(posedge clk);
    #1;
    checkResetState("rst");
    reset = 1'b1;

    // Single write from requester 0.
    sReq = 4'b0001; sRw[0] = 1'b0;
    sAddr[0] = 7'h50; sBlock[0] = 8'h10; sData[0] = 8'hA5;
    applyStimulus();
    doTransfer(40, 1'b0, 1'b0, 8'($urandom), 1'b1);

    // Read from requester 2.
    sReq = 4'b0100; sRw[2] = 1'b1;
    sAddr[2] = 7'h50; sBlock[2] = 8'h20;
    applyStimulus();
    doTransfer(12, 1'b0, 1'b0, 8'h3C, 1'b1);

    // Master never starts: timeout.
    sReq = 4'b1000;
    applyStimulus();
    doTransfer(0, 1'b1, 1'b0, 8'h00, 1'b0);

    // Requester 1 changes its data from 0x11 to 0xFF mid-transfer.
    sReq = 4'b0010; sData[1] = 8'h11;
    applyStimulus();
    doTransfer(10, 1'b0, 1'b1, 8'($urandom), 1'b0);
    checkOutput("payloadChg.req", 32'(sData[1]), 32'hFF);
    sReq = '0;
    applyStimulus();

    // Reset during WAIT_DONE.
    sReq = 4'b0100;
    mdlNoBusy = 1'b0; mdlLen = 40;
    applyStimulus();
    repeat (4) begin
      @(posedge clk); #1;
    end
    reset = 1'b0;
    @(posedge clk); #1;
    checkResetState("midRst");
    reset  = 1'b1;
    mdlPtr = 0;
    sReq   = '0;
    applyStimulus();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checkOutput("midRst.noDone", 32'(bus.done), 32'd0);
    end

    // Full contention: grant order 0,1,2,3,0 from ptr=0.
    sReq = '1;
    randomizePayloads();
    applyStimulus();
    for (int t = 0; t < 5; t++) doTransfer(3, 1'b0, 1'b1, 8'($urandom), 1'($urandom));
    sReq = '0;
    applyStimulus();

    // Randomized traffic.
    for (int t = 0; t < 40; t++) begin
      sReq = sReq | N'($urandom);
      if (sReq == '0) sReq[$urandom_range(0, N-1)] = 1'b1;
      randomizePayloads();
      applyStimulus();
      doTransfer($urandom_range(1, 12), ($urandom_range(0, 7) == 0), 1'b0,
                 8'($urandom), 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
